// File: rtl/sketch_reader_if.sv
// Output stream of the bottom-k sketch reader.
//   out_valid     : an entry is presented (producer -> consumer)
//   out_ready     : consumer accepts the entry (consumer -> producer)
//   out_signature : presented signature
//   out_index     : presented index
//   out_rank      : 0-based ascending position of the entry
//   out_last      : presented entry is the final one of the read-out
// master = producer (sketch_reader), slave = consumer.
interface sketch_reader_if #(
  parameter int SIGNATURE_WIDTH = 32,
  parameter int INDEX_WIDTH     = 10,
  parameter int LOG_COMPARATORS = 3
);
  logic                       out_valid;
  logic                       out_ready;
  logic [SIGNATURE_WIDTH-1:0] out_signature;
  logic [INDEX_WIDTH-1:0]     out_index;
  logic [LOG_COMPARATORS-1:0] out_rank;
  logic                       out_last;

  modport master (
    output out_valid, out_signature, out_index, out_rank, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_signature, out_index, out_rank, out_last,
    output out_ready
  );
endinterface

// File: rtl/sketch_reader.sv
// Read-out side of the bottom-k MinHash sorter. A start pulse snapshots the
// sorter's signature/index arrays; the non-empty entries (signature != all
// ones) are then streamed in ascending signature order, ties resolved by the
// lowest slot number, one entry per SELECT/EMIT pair.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : read-out request, sampled only in IDLE
//   signatures_in : sorter signature array
//   indices_in    : sorter index array
//   busy          : high from the snapshot until done
//   entry_count   : number of non-empty entries in the snapshot
//   stream        : valid/ready output stream (sketch_reader_if.master)
//   done          : one-cycle pulse when the read-out completes
module sketch_reader #(
  parameter int SIGNATURE_WIDTH = 32,
  parameter int INDEX_WIDTH     = 10,
  parameter int NUM_COMPARATORS = 8,
  parameter int LOG_COMPARATORS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SIGNATURE_WIDTH-1:0] signatures_in [NUM_COMPARATORS],
  input  logic [INDEX_WIDTH-1:0]     indices_in    [NUM_COMPARATORS],
  output logic                       busy,
  output logic [LOG_COMPARATORS:0]   entry_count,
  sketch_reader_if.master            stream,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, SELECT, EMIT} state_t;

  state_t state, state_next;

  logic [SIGNATURE_WIDTH-1:0] sig_q [NUM_COMPARATORS];
  logic [INDEX_WIDTH-1:0]     idx_q [NUM_COMPARATORS];
  logic [NUM_COMPARATORS-1:0] pending;

  logic [NUM_COMPARATORS-1:0] snap_mask;
  logic [LOG_COMPARATORS:0]   snap_count;
  logic [LOG_COMPARATORS:0]   pend_count;
  logic                       pending_one;
  logic                       win_found;
  logic [LOG_COMPARATORS-1:0] win_slot;
  logic [SIGNATURE_WIDTH-1:0] win_sig;

  logic snap_take, sel_take, hs_take;

  // Non-empty mask and its popcount, taken straight from the live inputs.
  always_comb begin
    snap_mask  = '0;
    snap_count = '0;
    for (int unsigned i = 0; i < NUM_COMPARATORS; i++) begin
      snap_mask[i] = (signatures_in[i] != '1);
      snap_count   = snap_count + {{LOG_COMPARATORS{1'b0}}, snap_mask[i]};
    end
  end

  // Argmin over pending slots; strict '<' scanning upward keeps the lowest
  // slot on equal signatures.
  always_comb begin
    win_found  = 1'b0;
    win_slot   = '0;
    win_sig    = '1;
    pend_count = '0;
    for (int unsigned i = 0; i < NUM_COMPARATORS; i++) begin
      pend_count = pend_count + {{LOG_COMPARATORS{1'b0}}, pending[i]};
      if (pending[i] && (!win_found || sig_q[i] < win_sig)) begin
        win_found = 1'b1;
        win_slot  = LOG_COMPARATORS'(i);
        win_sig   = sig_q[i];
      end
    end
    pending_one = (pend_count == {{LOG_COMPARATORS{1'b0}}, 1'b1});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap_take  = 1'b0;
    sel_take   = 1'b0;
    hs_take    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          snap_take  = 1'b1;
          state_next = (snap_mask == '0) ? IDLE : SELECT;
        end
      end
      SELECT: begin
        sel_take   = 1'b1;
        state_next = EMIT;
      end
      EMIT: begin
        if (stream.out_valid && stream.out_ready) begin
          hs_take    = 1'b1;
          state_next = stream.out_last ? IDLE : SELECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_COMPARATORS; i++) begin
        sig_q[i] <= '0;
        idx_q[i] <= '0;
      end
      pending              <= '0;
      entry_count          <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      stream.out_valid     <= 1'b0;
      stream.out_last      <= 1'b0;
      stream.out_signature <= '0;
      stream.out_index     <= '0;
      stream.out_rank      <= '0;
    end else begin
      done <= 1'b0;

      if (snap_take) begin
        for (int unsigned i = 0; i < NUM_COMPARATORS; i++) begin
          sig_q[i] <= signatures_in[i];
          idx_q[i] <= indices_in[i];
        end
        pending         <= snap_mask;
        entry_count     <= snap_count;
        stream.out_rank <= '0;
        if (snap_mask == '0) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          busy <= 1'b1;
        end
      end

      if (sel_take) begin
        stream.out_signature <= sig_q[win_slot];
        stream.out_index     <= idx_q[win_slot];
        stream.out_valid     <= 1'b1;
        stream.out_last      <= pending_one;
      end

      // pending is untouched between SELECT and the handshake, so win_slot
      // still names the presented entry here.
      if (hs_take) begin
        pending[win_slot] <= 1'b0;
        stream.out_valid  <= 1'b0;
        if (stream.out_last) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          stream.out_rank <= stream.out_rank + 1'b1;
        end
      end
    end
  end

endmodule
